mul_accumulate_stage: RTL and testbench
=======================================

// Module: mul_accumulate_stage
// PURPOSE
//  Downstream consumer of the 16x16 array multiplier's 32-bit product.
//  Sums a programmed number of products (unsigned) into a wide saturating accumulator.
//  Presents the result on a valid/ready output port and holds it until taken.
//  The result feeds the next datapath stage.
//  Sits between the combinational multiplier and any register or consumer that needs dot-product style sums.
// PARAMETERS
//  PROD_WIDTH  32  width of incoming product (matches the 16x16 multiplier output)
//  ACC_WIDTH   40  accumulator width; must be >= PROD_WIDTH+1
//  CNT_WIDTH   8   width of the beat-count (length) field
// PORTS
//  Clock          in   1           single clock; all state updates on rising edge
//  Reset          in   1           asynchronous, active-high reset
//  iStart         in   1           start a new accumulation (sampled only in IDLE)
//  iLength        in   CNT_WIDTH   number of products to sum; latched with iStart
//  iProduct       in   PROD_WIDTH  product from multiplier, unsigned
//  iProductValid  in   1           iProduct is valid this cycle
//  oProductReady  out  1           stage accepts a product this cycle
//  oAcc           out  ACC_WIDTH   accumulated sum (registered)
//  oAccValid      out  1           oAcc holds a completed result
//  iAccReady      in   1           downstream takes oAcc this cycle
//  oOverflow      out  1           sticky: saturation occurred in the current or last run
//  oBusy          out  1           high in RUN or HOLD
// BEHAVIOUR
//  Reset (async, any state, mid-run included):
//   - State goes to IDLE.
//   - oAcc=0, oAccValid=0, oOverflow=0, oBusy=0, oProductReady=0.
//   - Beat counter=0 and latched length=0.
//   - Any partial sum is discarded.
//  FSM states: IDLE, RUN, HOLD. Outputs decode from state:
//   - oProductReady = (state==RUN)
//   - oAccValid = (state==HOLD)
//   - oBusy = (state!=IDLE)
//  IDLE, on iStart:
//   - Latch iLength.
//   - Clear oAcc to 0, clear the beat counter and clear oOverflow.
//   - If iLength!=0, go to RUN. If iLength==0, go directly to HOLD (result 0).
//  RUN:
//   - A beat is accepted when iProductValid & oProductReady.
//   - On each beat: oAcc <= oAcc + zero-extended iProduct, and count += 1.
//   - Cycles with iProductValid low are idle; no state change.
//   - The beat taking count to length moves state to HOLD.
//   - oAccValid rises on the cycle after the final beat is accepted; latency is 1 clock.
//  Saturation:
//   - If the ACC_WIDTH+1-bit sum has its carry set, oAcc <= all ones and oOverflow <= 1.
//   - Later beats keep oAcc saturated.
//   - oOverflow stays high until the next accepted iStart.
//  HOLD:
//   - oAcc is stable and oAccValid=1.
//   - On iAccReady=1, go to IDLE; oAcc keeps its value and oAccValid drops the next cycle.
//  iStart outside IDLE is ignored, including in the same cycle as the HOLD->IDLE handshake.
//   - A new start must be issued in IDLE.
//  The counter wraps nowhere: the maximum length is 2^CNT_WIDTH-1 beats.
// TESTING
//  T1: iStart with iLength=3; products 0x2, 0x3, 0x5 on consecutive cycles
//      -> oAccValid=1 one cycle after the 3rd beat, oAcc=0xA, oOverflow=0.
//  T2: iLength=4; products 0x10 each, iProductValid toggling 1,0,0,1,1,0,1
//      -> only 4 beats are counted; oAcc=0x40; HOLD is entered after the 4th valid beat.
//  T3: ACC_WIDTH=33, iLength=3; products 0xFFFF_FFFF x3
//      -> oAcc=0x1_FFFF_FFFF (saturated), oOverflow=1.
//      -> A new iStart then clears oOverflow to 0.
//  T4: iStart with iLength=0
//      -> oAccValid=1 next cycle with oAcc=0; oProductReady never asserts.
//  T5: in HOLD, hold iAccReady=0 for 5 cycles and pulse iStart
//      -> oAcc is unchanged and iStart is ignored.
//      -> iAccReady=1 gives IDLE on the next cycle.
//  T6: assert Reset mid-RUN after 2 of 5 beats
//      -> all outputs are 0 immediately, state is IDLE.
//      -> A following iLength=1 run with product 0x7 gives oAcc=0x7.

Source files
------------

// File: rtl/mul_accumulate_stage.sv
// ---------------------------------------------------------------------------
// mul_accumulate_stage
//
// Purpose:
//   Sums a programmed number of unsigned products coming from the 16x16 array
//   multiplier into a wide, saturating accumulator. When the programmed
//   number of beats has been summed, the result is presented on a
//   valid/ready port and held until the downstream stage takes it. This is
//   the dot-product style reduction stage that sits between the
//   combinational multiplier and the next register or consumer.
//
// Parameters:
//   PROD_WIDTH  width of the incoming product (32 for the 16x16 multiplier)
//   ACC_WIDTH   accumulator width; must be at least PROD_WIDTH+1
//   CNT_WIDTH   width of the beat-count field; longest run is
//               2^CNT_WIDTH-1 beats
//
// Ports:
//   Clock          in   single clock, all state changes on the rising edge
//   Reset          in   asynchronous, active-high reset
//   iStart         in   begin a new accumulation (only honoured in IDLE)
//   iLength        in   number of products to sum, latched with iStart
//   iProduct       in   unsigned product from the multiplier
//   iProductValid  in   iProduct carries a product this cycle
//   oProductReady  out  stage accepts a product this cycle (RUN)
//   oAcc           out  registered accumulated sum
//   oAccValid      out  oAcc holds a completed result (HOLD)
//   iAccReady      in   downstream takes oAcc this cycle
//   oOverflow      out  sticky saturation flag for the current/last run
//   oBusy          out  stage is in RUN or HOLD
// ---------------------------------------------------------------------------
module mul_accumulate_stage #(
  parameter int PROD_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [CNT_WIDTH-1:0]  iLength,
  input  logic [PROD_WIDTH-1:0] iProduct,
  input  logic                  iProductValid,
  output logic                  oProductReady,
  output logic [ACC_WIDTH-1:0]  oAcc,
  output logic                  oAccValid,
  input  logic                  iAccReady,
  output logic                  oOverflow,
  output logic                  oBusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;

  logic [CNT_WIDTH-1:0]   count;
  logic [CNT_WIDTH-1:0]   length;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   overflow;

  logic                   start_accept;
  logic                   beat;
  logic                   final_beat;
  logic [ACC_WIDTH:0]     sum;
  logic [CNT_WIDTH:0]     count_inc;

  // A start is only meaningful while idle; a start that arrives together
  // with the HOLD->IDLE handshake is dropped because state is still HOLD.
  assign start_accept = (state == IDLE) && iStart;
  assign beat         = (state == RUN) && iProductValid;

  // One extra bit on the sum exposes the carry that drives saturation.
  assign sum = {1'b0, acc} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, iProduct};

  // The counter is compared one ahead so the beat that reaches the latched
  // length is the one that moves the FSM to HOLD. The extra bit keeps the
  // comparison exact for the longest run without any wrap.
  assign count_inc  = {1'b0, count} + (CNT_WIDTH + 1)'(1);
  assign final_beat = beat && (count_inc == {1'b0, length});

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode. A zero-length start skips RUN entirely and presents
  // an empty (zero) result straight away.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (iStart) begin
          if (iLength == '0) begin
            state_next = HOLD;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (final_beat) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (iAccReady) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Run bookkeeping: the length is captured with the start and the beat
  // counter advances once per accepted product.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      length <= '0;
      count  <= '0;
    end else if (start_accept) begin
      length <= iLength;
      count  <= '0;
    end else if (beat) begin
      count <= count_inc[CNT_WIDTH-1:0];
    end
  end

  // Accumulator and sticky overflow. Once saturated the accumulator is all
  // ones, so any further non-zero product carries again and adding zero
  // leaves it unchanged -- saturation therefore persists for the whole run.
  // After the run the value is simply held; it is only cleared by the next
  // accepted start or by reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (start_accept) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (beat) begin
      if (sum[ACC_WIDTH]) begin
        acc      <= '1;
        overflow <= 1'b1;
      end else begin
        acc <= sum[ACC_WIDTH-1:0];
      end
    end
  end

  assign oProductReady = (state == RUN);
  assign oAccValid     = (state == HOLD);
  assign oBusy         = (state != IDLE);
  assign oAcc          = acc;
  assign oOverflow     = overflow;

endmodule

// File: tb/tb_mul_accumulate_stage.sv
// ---------------------------------------------------------------------------
// tb_mul_accumulate_stage
//
// Self-checking bench for mul_accumulate_stage. A run-level model (phase,
// beats remaining, saturating wide sum) follows the DUT inputs and every
// falling edge the DUT outputs are compared against it. Directed sequences
// pin the model to hand-computed results, then a randomized phase drives
// arbitrary starts, lengths, product valids, handshakes and resets.
// The accumulator is built 33 bits wide so saturation is easy to reach.
// ---------------------------------------------------------------------------
module tb_mul_accumulate_stage;

  localparam int PW = 32;
  localparam int AW = 33;
  localparam int CW = 8;
  localparam longint unsigned ACC_MAX = (64'd1 << AW) - 64'd1;

  logic          Clock;
  logic          Reset;
  logic          iStart;
  logic [CW-1:0] iLength;
  logic [PW-1:0] iProduct;
  logic          iProductValid;
  logic          oProductReady;
  logic [AW-1:0] oAcc;
  logic          oAccValid;
  logic          iAccReady;
  logic          oOverflow;
  logic          oBusy;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0 = waiting for a start, 1 = collecting products,
  // 2 = result presented.
  int              m_phase = 0;
  int              m_left  = 0;
  longint unsigned m_sum   = 0;
  logic            m_ovf   = 1'b0;

  mul_accumulate_stage #(
    .PROD_WIDTH (PW),
    .ACC_WIDTH  (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iStart        (iStart),
    .iLength       (iLength),
    .iProduct      (iProduct),
    .iProductValid (iProductValid),
    .oProductReady (oProductReady),
    .oAcc          (oAcc),
    .oAccValid     (oAccValid),
    .iAccReady     (iAccReady),
    .oOverflow     (oOverflow),
    .oBusy         (oBusy)
  );

  // Free-running clock, period 10.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Compare one observed value with its required value.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: reacts to the same edges the DUT does, using the
  // run-level rules (sum the products, clamp at the accumulator maximum).
  initial begin
    longint unsigned s;
    forever begin
      @(posedge Clock or posedge Reset);
      if (Reset) begin
        m_phase = 0;
        m_left  = 0;
        m_sum   = 0;
        m_ovf   = 1'b0;
      end else begin
        case (m_phase)
          0: begin
            if (iStart) begin
              m_sum   = 0;
              m_ovf   = 1'b0;
              m_left  = int'(iLength);
              m_phase = (iLength == 0) ? 2 : 1;
            end
          end
          1: begin
            if (iProductValid) begin
              s = m_sum + longint'(iProduct);
              if (s > ACC_MAX) begin
                s     = ACC_MAX;
                m_ovf = 1'b1;
              end
              m_sum  = s;
              m_left = m_left - 1;
              if (m_left == 0) m_phase = 2;
            end
          end
          default: begin
            if (iAccReady) m_phase = 0;
          end
        endcase
      end
    end
  end

  // Every falling edge all outputs are compared with the model.
  always @(negedge Clock) begin
    checkOutput("cmp_ready", 64'(oProductReady), 64'(m_phase == 1));
    checkOutput("cmp_valid", 64'(oAccValid),     64'(m_phase == 2));
    checkOutput("cmp_busy",  64'(oBusy),         64'(m_phase != 0));
    checkOutput("cmp_acc",   64'(oAcc),          m_sum);
    checkOutput("cmp_ovf",   64'(oOverflow),     64'(m_ovf));
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Drive one cycle's worth of inputs and advance.
  task automatic applyStimulus(input logic start, input logic [CW-1:0] len,
                               input logic pvalid, input logic [PW-1:0] prod,
                               input logic ready);
    iStart        = start;
    iLength       = len;
    iProductValid = pvalid;
    iProduct      = prod;
    iAccReady     = ready;
    tick();
  endtask

  // Take the presented result and return to idle.
  task automatic handshake();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    iAccReady = 1'b0;
  endtask

  initial begin
    logic [6:0] pat;

    Reset         = 1'b1;
    iStart        = 1'b0;
    iLength       = '0;
    iProduct      = '0;
    iProductValid = 1'b0;
    iAccReady     = 1'b0;

    // Reset values.
    tick();
    checkOutput("rst_acc",   64'(oAcc), 64'h0);
    checkOutput("rst_valid", 64'(oAccValid), 64'h0);
    checkOutput("rst_busy",  64'(oBusy), 64'h0);
    checkOutput("rst_ready", 64'(oProductReady), 64'h0);
    checkOutput("rst_ovf",   64'(oOverflow), 64'h0);
    tick();
    Reset = 1'b0;
    tick();

    // Three consecutive beats 2+3+5; valid the cycle after the last one.
    applyStimulus(1'b1, 8'd3, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 32'h2, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 32'h3, 1'b0);
    checkOutput("t1_not_yet", 64'(oAccValid), 64'h0);
    applyStimulus(1'b0, '0, 1'b1, 32'h5, 1'b0);
    iProductValid = 1'b0;
    checkOutput("t1_valid", 64'(oAccValid), 64'h1);
    checkOutput("t1_acc",   64'(oAcc), 64'hA);
    checkOutput("t1_model", m_sum, 64'hA);
    checkOutput("t1_ovf",   64'(oOverflow), 64'h0);
    handshake();
    checkOutput("t1_idle_valid", 64'(oAccValid), 64'h0);
    checkOutput("t1_idle_acc",   64'(oAcc), 64'hA);

    // Gapped valids: only the four valid cycles count.
    pat = 7'b1011001;
    applyStimulus(1'b1, 8'd4, 1'b0, '0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, '0, pat[i], 32'h10, 1'b0);
      if (i == 4) begin
        checkOutput("t2_mid_valid", 64'(oAccValid), 64'h0);
        checkOutput("t2_mid_acc",   64'(oAcc), 64'h30);
      end
    end
    iProductValid = 1'b0;
    checkOutput("t2_valid", 64'(oAccValid), 64'h1);
    checkOutput("t2_acc",   64'(oAcc), 64'h40);
    checkOutput("t2_model", m_sum, 64'h40);
    handshake();

    // Saturation with three full-scale products in a 33-bit accumulator.
    applyStimulus(1'b1, 8'd3, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    iProductValid = 1'b0;
    checkOutput("t3_acc",   64'(oAcc), 64'h1_FFFF_FFFF);
    checkOutput("t3_model", m_sum, 64'h1_FFFF_FFFF);
    checkOutput("t3_ovf",   64'(oOverflow), 64'h1);
    handshake();
    checkOutput("t3_ovf_sticky", 64'(oOverflow), 64'h1);
    applyStimulus(1'b1, 8'd1, 1'b0, '0, 1'b0);
    checkOutput("t3_ovf_clear", 64'(oOverflow), 64'h0);
    checkOutput("t3_acc_clear", 64'(oAcc), 64'h0);
    applyStimulus(1'b0, '0, 1'b1, 32'h1, 1'b0);
    iProductValid = 1'b0;
    checkOutput("t3_next_acc", 64'(oAcc), 64'h1);
    handshake();

    // Zero length: immediate empty result, never ready for products.
    applyStimulus(1'b1, 8'd0, 1'b0, '0, 1'b0);
    checkOutput("t4_valid", 64'(oAccValid), 64'h1);
    checkOutput("t4_acc",   64'(oAcc), 64'h0);
    checkOutput("t4_ready", 64'(oProductReady), 64'h0);
    applyStimulus(1'b0, '0, 1'b1, 32'h55, 1'b0);
    iProductValid = 1'b0;
    checkOutput("t4_ready2", 64'(oProductReady), 64'h0);
    checkOutput("t4_acc2",   64'(oAcc), 64'h0);
    handshake();

    // Held result survives back-pressure and ignored starts.
    applyStimulus(1'b1, 8'd2, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 32'h4, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 32'h6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i[0], 8'd3, 1'b0, '0, 1'b0);
      checkOutput("t5_hold_acc",   64'(oAcc), 64'hA);
      checkOutput("t5_hold_valid", 64'(oAccValid), 64'h1);
    end
    applyStimulus(1'b1, 8'd3, 1'b0, '0, 1'b1);
    iStart    = 1'b0;
    iAccReady = 1'b0;
    checkOutput("t5_idle_busy",  64'(oBusy), 64'h0);
    checkOutput("t5_idle_valid", 64'(oAccValid), 64'h0);
    checkOutput("t5_idle_acc",   64'(oAcc), 64'hA);
    tick();
    checkOutput("t5_start_ignored", 64'(oBusy), 64'h0);

    // Asynchronous reset in the middle of a run.
    applyStimulus(1'b1, 8'd5, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 32'h3, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 32'h4, 1'b0);
    iProduct = 32'h9;
    #2 Reset = 1'b1;
    #1;
    checkOutput("t6_acc",   64'(oAcc), 64'h0);
    checkOutput("t6_busy",  64'(oBusy), 64'h0);
    checkOutput("t6_ready", 64'(oProductReady), 64'h0);
    checkOutput("t6_valid", 64'(oAccValid), 64'h0);
    checkOutput("t6_ovf",   64'(oOverflow), 64'h0);
    iProductValid = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    applyStimulus(1'b1, 8'd1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 32'h7, 1'b0);
    iProductValid = 1'b0;
    checkOutput("t6_after_acc",   64'(oAcc), 64'h7);
    checkOutput("t6_after_valid", 64'(oAccValid), 64'h1);
    handshake();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [CW-1:0] len;
      logic [PW-1:0] prod;
      len  = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 40))
                                         : CW'($urandom_range(0, 6));
      prod = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      Reset = ($urandom_range(0, 299) == 0);
      applyStimulus($urandom_range(0, 9) < 3, len, $urandom_range(0, 9) < 7,
                    prod, $urandom_range(0, 9) < 4);
    end
    Reset         = 1'b0;
    iStart        = 1'b0;
    iProductValid = 1'b0;
    iAccReady     = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
